// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: access sizes, FSM states,
// and the misalignment rule used to reject requests before any RAM access.
package dmem_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeIllegal = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRdWait = 2'b01,
    StRmwWr  = 2'b10,
    StResp   = 2'b11
  } state_e;

  function automatic logic req_misaligned(size_e size, logic [1:0] off);
    case (size)
      SizeByte: return 1'b0;
      SizeHalf: return off[0];
      SizeWord: return off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane handling: extract+extend a sub-word for loads, and merge
// right-aligned store data into the lane(s) of an existing word for read-modify-write.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            off_i,
  input  size_e                 size_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] load_o,
  output logic [DATA_WIDTH-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merge_o  = wdata_i;
    case (size_i)
      SizeByte: begin
        load_o  = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_o = word_i;
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SizeHalf: begin
        load_o  = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]} : {word_i[31:16], wdata_i[15:0]};
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// CPU load/store front-end for a single-port-style synchronous RAM. Requests are fully
// serialised; sub-word stores go through a read-modify-write cycle.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  size_e                 size_q;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [ADDR_WIDTH-1:0] req_word;
  size_e                 req_size_e;
  logic                  idle, accept, req_err, word_store;
  logic [DATA_WIDTH-1:0] load_data, merge_data;

  assign req_word   = req_addr[ADDR_WIDTH+1:2];
  assign req_size_e = size_e'(req_size);
  assign idle       = (state_q == StIdle);
  assign req_ready  = idle & ~rst;
  assign accept     = req_valid & req_ready;
  assign req_err    = req_misaligned(req_size_e, req_addr[1:0]);
  assign word_store = req_we & (req_size_e == SizeWord) & ~req_err;

  // Word stores write straight from the request in the accept cycle; RMW writes
  // use the latched request merged with the word read one cycle earlier.
  assign ram_read_addr  = idle ? req_word : addr_q;
  assign ram_write_addr = idle ? req_word : addr_q;
  assign ram_data       = idle ? req_wdata : merge_data;
  assign ram_we         = ~rst & ((accept & word_store) | (state_q == StRmwWr));

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  dmem_lane_unit u_lane (
    .word_i   (ram_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (word_store) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
          end else if (req_we) begin
            state_d = StRmwWr;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
      end
      StRmwWr: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      off_q        <= '0;
      size_q       <= SizeByte;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      if (accept) begin
        addr_q   <= req_word;
        off_q    <= req_addr[1:0];
        size_q   <= req_size_e;
        signed_q <= req_signed;
        wdata_q  <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench: a reference memory model predicts each response and RAM write
// when a request is accepted; monitors pop and compare when the DUT produces them.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  ram_read_addr;
  logic [5:0]  ram_write_addr;
  logic [31:0] ram_data;
  logic        ram_we;
  logic [31:0] ram_q = 32'h0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  logic  prev_we = 1'b0;

  dmem_access_ctrl #(.ADDR_WIDTH(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .ram_read_addr  (ram_read_addr),
    .ram_write_addr (ram_write_addr),
    .ram_data       (ram_data),
    .ram_we         (ram_we),
    .ram_q          (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM returning old data on read-during-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: predicts response and RAM write for an accepted request at cycle t.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [7:0] addr, input logic [31:0] wdata, input int t);
    logic [1:0]  off;
    logic [5:0]  wa;
    logic [31:0] w, nw, rd;
    logic [7:0]  b;
    logic [15:0] h;
    logic        err;
    off = addr[1:0];
    wa  = addr[7:2];
    w   = ref_mem[wa];
    err = (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
    if (err) begin
      rq.push_back('{rdata: 32'h0, err: 1'b1, due: t + 1});
    end else if (we && size == 2'b10) begin
      wq.push_back('{addr: wa, data: wdata, due: t});
      ref_mem[wa] = wdata;
      rq.push_back('{rdata: 32'h0, err: 1'b0, due: t + 1});
    end else if (we) begin
      nw = w;
      if (size == 2'b00) nw[8*off +: 8] = wdata[7:0];
      else if (off[1]) nw[31:16] = wdata[15:0];
      else nw[15:0] = wdata[15:0];
      wq.push_back('{addr: wa, data: nw, due: t + 1});
      ref_mem[wa] = nw;
      rq.push_back('{rdata: 32'h0, err: 1'b0, due: t + 2});
    end else begin
      b = w[8*off +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      if (size == 2'b00) rd = {{24{sgn & b[7]}}, b};
      else if (size == 2'b01) rd = {{16{sgn & h[15]}}, h};
      else rd = w;
      rq.push_back('{rdata: rd, err: 1'b0, due: t + 2});
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [7:0] addr, input logic [31:0] wdata);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (req_ready) begin
      model(we, size, sgn, addr, wdata, cyc);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (resp_valid) begin
      chk("resp_pending", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        chk("resp_cycle", cyc, e.due);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
    if (ram_we) begin
      chk("we_single_cycle", 32'(prev_we), 32'd0);
      chk("wr_pending", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.due);
        chk("wr_addr", 32'(ram_write_addr), 32'(w.addr));
        chk("wr_data", ram_data, w.data);
      end
    end
    prev_we = ram_we;
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[0]     = 32'h8844_2211;
    ref_mem[0] = 32'h8844_2211;

    // Reset with an aligned word store presented: nothing may be accepted or written.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 8'h10;
    req_wdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    send(1'b0, 2'b00, 1'b1, 8'h03, 32'h0);          // -> FFFFFF88
    gap(1);
    send(1'b0, 2'b00, 1'b0, 8'h03, 32'h0);          // -> 00000088
    gap(1);
    send(1'b1, 2'b10, 1'b0, 8'h04, 32'hDEAD_BEEF);
    gap(1);
    send(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
    gap(1);
    send(1'b1, 2'b01, 1'b0, 8'h02, 32'h0000_1234);  // word0 -> 12342211
    gap(1);
    send(1'b0, 2'b01, 1'b1, 8'h02, 32'h0);
    gap(1);
    send(1'b0, 2'b10, 1'b0, 8'h05, 32'h0);          // misaligned word
    gap(1);
    send(1'b0, 2'b11, 1'b0, 8'h00, 32'h0);          // illegal size
    gap(1);
    send(1'b1, 2'b10, 1'b0, 8'h06, 32'h1111_2222);  // misaligned store, no write
    gap(1);
    send(1'b1, 2'b01, 1'b0, 8'h03, 32'h0000_5555);  // misaligned half store
    gap(1);

    // Back-to-back with req_valid held high.
    send(1'b1, 2'b00, 1'b0, 8'h09, 32'h0000_00A5);
    send(1'b0, 2'b00, 1'b0, 8'h09, 32'h0);
    send(1'b0, 2'b01, 1'b1, 8'h0A, 32'h0);
    send(1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
    gap(2);

    for (int i = 0; i < 24; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 63)), $urandom);
      gap(int'($urandom_range(0, 1)));
    end
    gap(3);

    // Reset during the RMW write of a byte store: write and response must vanish.
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 8'h01;
    req_wdata  = 32'h0000_0077;
    req_valid  = 1'b1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(ram_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    gap(3);
    send(1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
    gap(2);

    for (int i = 0; i < 50 && (rq.size() != 0 || wq.size() != 0); i++) @(posedge clk);
    chk("resp_q_drained", 32'(rq.size()), 32'd0);
    chk("wr_q_drained", 32'(wq.size()), 32'd0);
    #1;
    for (int i = 0; i < 17; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
